// File: rtl/uart_event_deframer_if.sv
// Byte-in / event-out handshake bundle for the UART event deframer.
// The slave view belongs to the deframer. The master view belongs to the byte source and event sink.
interface uart_event_deframer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       event_valid;
  logic [8:0] event_x;
  logic [8:0] event_y;
  logic       event_polarity;
  logic       event_ready;

  modport master (
    output rx_data, rx_valid, event_ready,
    input  event_valid, event_x, event_y, event_polarity
  );

  modport slave (
    input  rx_data, rx_valid, event_ready,
    output event_valid, event_x, event_y, event_polarity
  );
endinterface

// File: rtl/uart_event_deframer.sv
// Parses 5-byte [X_HI,X_LO,Y_HI,Y_LO,POL] packets and the 0xFF/0xFE commands from a UART byte
// stream. Valid events are buffered in a first-word-fall-through FIFO with error and drop counters.
module uart_event_deframer #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SENSOR_RES     = 320,
  parameter int unsigned TIMEOUT_CYCLES = 5208
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uart_event_deframer_if.slave          bus,
  output logic                          cmd_echo,
  output logic                          cmd_status,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   drop_count,
  output logic [15:0]                   err_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {SXHi, SXLo, SYHi, SYLo, SPol} state_e;

  state_e            state_d, state_q;
  logic              x_hi_d, x_hi_q, y_hi_d, y_hi_q;
  logic [7:0]        x_lo_d, x_lo_q, y_lo_d, y_lo_q;
  logic [TmoW-1:0]   idle_d, idle_q;
  logic              echo_d, echo_q, status_d, status_q;
  logic [PtrW-1:0]   wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CntW-1:0]   count_d, count_q;
  logic [15:0]       err_d, err_q, drop_d, drop_q;
  logic [18:0]       mem_q [FIFO_DEPTH];

  logic              parse_err, evt_done, range_err, fifo_full, push, pop;
  logic [8:0]        evt_x, evt_y;

  always_comb begin
    state_d   = state_q;
    x_hi_d    = x_hi_q;
    x_lo_d    = x_lo_q;
    y_hi_d    = y_hi_q;
    y_lo_d    = y_lo_q;
    idle_d    = idle_q;
    echo_d    = 1'b0;
    status_d  = 1'b0;
    parse_err = 1'b0;
    evt_done  = 1'b0;
    if (bus.rx_valid) begin
      // A byte arriving in the timeout cycle is processed; the timeout is not taken.
      idle_d = '0;
      case (state_q)
        SXHi: begin
          if (bus.rx_data == 8'hFF) begin
            echo_d = 1'b1;
          end else if (bus.rx_data == 8'hFE) begin
            status_d = 1'b1;
          end else if (bus.rx_data[7:1] == 7'd0) begin
            x_hi_d  = bus.rx_data[0];
            state_d = SXLo;
          end else begin
            parse_err = 1'b1;
          end
        end
        SXLo: begin
          x_lo_d  = bus.rx_data;
          state_d = SYHi;
        end
        SYHi: begin
          if (bus.rx_data[7:1] == 7'd0) begin
            y_hi_d  = bus.rx_data[0];
            state_d = SYLo;
          end else begin
            parse_err = 1'b1;
            state_d   = SXHi;
          end
        end
        SYLo: begin
          y_lo_d  = bus.rx_data;
          state_d = SPol;
        end
        SPol: begin
          evt_done = 1'b1;
          state_d  = SXHi;
        end
        default: state_d = SXHi;
      endcase
    end else if (state_q != SXHi && idle_q == TmoLast) begin
      parse_err = 1'b1;
      state_d   = SXHi;
      idle_d    = '0;
    end else if (idle_q != TmoLast) begin
      idle_d = idle_q + 1'b1;
    end
  end

  assign evt_x     = {x_hi_q, x_lo_q};
  assign evt_y     = {y_hi_q, y_lo_q};
  assign range_err = (32'(evt_x) >= SENSOR_RES) || (32'(evt_y) >= SENSOR_RES);
  assign fifo_full = (count_q == CntFull);
  assign push      = evt_done && !range_err && !fifo_full;
  assign pop       = (count_q != '0) && bus.event_ready;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    // Coincident error sources count once.
    err_d = err_q;
    if ((parse_err || (evt_done && range_err)) && err_q != 16'hFFFF) err_d = err_q + 1'b1;
    drop_d = drop_q;
    if (evt_done && !range_err && fifo_full && drop_q != 16'hFFFF) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SXHi;
      x_hi_q   <= 1'b0;
      x_lo_q   <= '0;
      y_hi_q   <= 1'b0;
      y_lo_q   <= '0;
      idle_q   <= '0;
      echo_q   <= 1'b0;
      status_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
      drop_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      x_hi_q   <= x_hi_d;
      x_lo_q   <= x_lo_d;
      y_hi_q   <= y_hi_d;
      y_lo_q   <= y_lo_d;
      idle_q   <= idle_d;
      echo_q   <= echo_d;
      status_q <= status_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      if (push) mem_q[wr_ptr_q] <= {evt_x, evt_y, bus.rx_data[0]};
    end
  end

  assign bus.event_valid = (count_q != '0);
  assign {bus.event_x, bus.event_y, bus.event_polarity} = mem_q[rd_ptr_q];
  assign cmd_echo   = echo_q;
  assign cmd_status = status_q;
  assign fifo_count = count_q;
  assign drop_count = drop_q;
  assign err_count  = err_q;

endmodule

// File: doc/uart_event_deframer.md
# uart_event_deframer

Byte-to-event deframer and event buffer between the UART receiver and the DVS gesture accelerator. It consumes the 8-bit `rx_data`/`rx_valid` byte stream and parses the 5-byte event packets `[X_HI, X_LO, Y_HI, Y_LO, POL]`. It also decodes the single-byte command codes 0xFF (echo) and 0xFE (status). Validated events go into a small FIFO with a valid/ready handshake, so the accelerator's `event_ready` backpressure causes no silent drops. Malformed, timed-out and overflowed packets are counted.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: event FIFO entries; must be a power of 2 and ≥2.
- `SENSOR_RES`, 320: a coordinate is valid only when it is < SENSOR_RES.
- `TIMEOUT_CYCLES`, 5208: maximum idle gap between bytes inside a packet. The default is about 5 byte-times at 115200 baud on a 12 MHz clock.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset; asynchronous assert, active-low.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe that qualifies `rx_data`.
- `event_valid` out 1: FIFO head is valid.
- `event_x` out 9: head X coordinate.
- `event_y` out 9: head Y coordinate.
- `event_polarity` out 1: head polarity (1 = ON).
- `event_ready` in 1: downstream accepts the head this cycle.
- `cmd_echo` out 1: one-cycle pulse when 0xFF is received at a packet boundary.
- `cmd_status` out 1: one-cycle pulse when 0xFE is received at a packet boundary.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `drop_count` out 16: number of valid events lost because the FIFO was full; saturating.
- `err_count` out 16: number of framing, range and timeout errors; saturating.

## Operation
The parser FSM has five states: S_X_HI, S_X_LO, S_Y_HI, S_Y_LO, S_POL. It advances only on `rx_valid`.

- **S_X_HI**
  - 0xFF: pulse `cmd_echo`, stay in S_X_HI.
  - 0xFE: pulse `cmd_status`, stay in S_X_HI.
  - Any other byte with bits[7:1]==0: latch x[8]=bit0, go to S_X_LO.
  - Any other byte with bits[7:1]!=0: `err_count`+1, stay in S_X_HI (resync).
- **S_X_LO**: latch x[7:0], go to S_Y_HI. Bytes 0xFF/0xFE are treated as data here; the same holds in every state other than S_X_HI.
- **S_Y_HI**
  - bits[7:1]==0: latch y[8], go to S_Y_LO.
  - Otherwise: `err_count`+1, go to S_X_HI.
- **S_Y_LO**: latch y[7:0], go to S_POL.
- **S_POL**: uses pol=bit0 of the byte; always returns to S_X_HI. The assembled event is handled in this priority order:
  - x≥SENSOR_RES or y≥SENSOR_RES: `err_count`+1, discard.
  - FIFO full: `drop_count`+1, discard.
  - Otherwise: push {x, y, pol}.
- **Timeout**
  - An idle counter clears on every `rx_valid` and increments otherwise.
  - If the state is not S_X_HI and the counter reaches TIMEOUT_CYCLES−1: `err_count`+1, go to S_X_HI, clear the counter.
  - If `rx_valid` arrives in the same cycle as the timeout, the byte wins: it is processed and no timeout is taken.
- **FIFO**
  - First-word fall-through. `event_valid` = !empty, and `event_x`/`event_y`/`event_polarity` present the entry at the read pointer.
  - Pop occurs when `event_valid && event_ready`.
  - Pointers wrap modulo FIFO_DEPTH; `fifo_count` is held in a separate counter.
- **Counter updates**
  - Push and pop in the same cycle: `fifo_count` is unchanged.
  - The full check uses the pre-cycle count. A push while full is rejected even if a pop happens in the same cycle.
  - When two error sources coincide in one cycle, `err_count` increments by 1 only.
  - `err_count` and `drop_count` hold at 0xFFFF.

## Timing
- **Reset** (asynchronous while `rst_n`=0):
  - FSM → S_X_HI; FIFO empty, with `event_valid`=0 and `fifo_count`=0.
  - `event_x`/`event_y`/`event_polarity` = 0.
  - `cmd_echo`=`cmd_status`=0; both error counters = 0; idle counter = 0.
  - A packet in progress at reset is lost and is not counted.
- **Latency**
  - POL byte `rx_valid` in cycle N → `event_valid`=1 in cycle N+1 (FIFO previously empty).
  - `cmd_echo`/`cmd_status` pulse in cycle N+1 after the command byte's strobe.
- **Handshake**: `event_valid` never drops without a pop, and the head data stays stable while `event_valid && !event_ready`.
- **Throughput**
  - Back-to-back `rx_valid` strobes, one per cycle, are accepted.
  - The FIFO sustains one pop per cycle alongside one push.

## Test plan
- Bytes 00,A0,01,05,01 with `event_ready`=1 → one event x=160, y=261, pol=1 with `event_valid` high one cycle after the POL strobe; all counters stay 0.
- 0xFF, then 0xFE, at idle → one `cmd_echo` pulse, then one `cmd_status` pulse; no event produced; FSM stays in S_X_HI. Also 00,FF,00,10,00 → event x=255, y=16, pol=0 (0xFF treated as data).
- `event_ready`=0 while sending 10 valid packets with FIFO_DEPTH=8 → `fifo_count`=8, `drop_count`=2. Then `event_ready`=1 → the first 8 events drain in send order, one per cycle.
- Packet with x=320 (01,40,…), then a packet with X_HI=0x02 → `err_count`=2, no push; the next valid packet is accepted.
- Send 00,10, then idle for TIMEOUT_CYCLES → `err_count`=1, FSM back in S_X_HI; a following full packet decodes correctly.
- Assert `rst_n`=0 asynchronously mid-packet with 3 events queued → all outputs clear immediately; after release, a fresh packet yields exactly one event.
